// File: rtl/lcd_pkg.sv
// Shared HD44780 command constants, default bus timing and scheduler state encoding.
package lcd_pkg;

  // HD44780 instruction bytes (written with rs=0)
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;

  // Default timing in clk cycles
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_PULSE_CYC = 50;
  localparam int DEF_CMD_CYC   = 2000;
  localparam int DEF_CLEAR_CYC = 90000;

  // Scheduler state encoding
  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  // Clear and home are the slow instructions; everything else uses the short wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module lcd_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,   // 1 = requester 1 was granted last
  output logic [1:0] grant_o
);

  // One-hot grant; a lone requester always wins, ties go against the last winner
  assign grant_o[0] = valid_i[0] & (~valid_i[1] | last_i);
  assign grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_i);

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Shares the HD44780 write bus between the init sequencer and two requesters,
// generating setup / enable pulse / post-write wait timing for each byte.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int CMD_CYC   = DEF_CMD_CYC,
  parameter int CLEAR_CYC = DEF_CLEAR_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] init_data,
  input  logic       init_rs,
  input  logic       init_e,
  input  logic       init_done,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       busy
);

  // Counter reload values: a phase of N cycles loads N-1 and counts down to 0
  localparam logic [31:0] SETUP_LD = 32'(SETUP_CYC - 1);
  localparam logic [31:0] PULSE_LD = 32'(PULSE_CYC - 1);
  localparam logic [31:0] CMD_LD   = 32'(CMD_CYC - 1);
  localparam logic [31:0] CLEAR_LD = 32'(CLEAR_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        last_q, last_d;
  logic [1:0]  grant;
  logic        in_idle;

  lcd_rr_arb2 u_arb (
    .valid_i ({req1_valid, req0_valid}),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign in_idle    = (state_q == S_IDLE);
  assign req0_ready = in_idle & grant[0];
  assign req1_ready = in_idle & grant[1];
  assign busy       = ~in_idle;
  assign lcd_rw     = 1'b0;

  // Bus mux: the init sequencer owns the pins until init_done, then the latched byte
  always_comb begin
    lcd_data = data_q;
    lcd_rs   = rs_q;
    lcd_e    = (state_q == S_PULSE);
    if (state_q == S_INIT) begin
      lcd_data = init_data;
      lcd_rs   = init_rs;
      lcd_e    = init_e;
    end
  end

  // Next-state logic: accept in IDLE, then SETUP -> PULSE -> WAIT, each counter-timed
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    last_d  = last_q;
    case (state_q)
      S_INIT: begin
        if (init_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req0_ready) begin
          data_d  = req0_data;
          rs_d    = req0_rs;
          last_d  = 1'b0;
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end else if (req1_ready) begin
          data_d  = req1_data;
          rs_d    = req1_rs;
          last_d  = 1'b1;
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (cnt_q == 32'd0) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_PULSE: begin
        if (cnt_q == 32'd0) begin
          state_d = S_WAIT;
          cnt_d   = is_long_cmd(rs_q, data_q) ? CLEAR_LD : CMD_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 32'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // State registers; reset hands the bus back to the init sequencer immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= 32'd0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed bench for lcd_bus_scheduler with short timing parameters.
module tb_lcd_bus_scheduler;

  localparam int SETUP = 2;
  localparam int PULSE = 4;
  localparam int CMDW  = 10;
  localparam int CLRW  = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] init_data;
  logic       init_rs, init_e, init_done;
  logic       req0_valid, req0_rs, req1_valid, req1_rs;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_e, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic       sel;
    logic       rs;
    logic [7:0] data;
    int         exp_wait;
  } vec_t;

  vec_t vecs[5];

  lcd_bus_scheduler #(
    .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .CMD_CYC(CMDW), .CLEAR_CYC(CLRW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .init_data(init_data), .init_rs(init_rs), .init_e(init_e), .init_done(init_done),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Release reset with init_done low, then give init_done one edge.
  task automatic bring_up();
    @(negedge clk);
    rst_n = 1'b1;
    init_done = 1'b1;
    @(posedge clk);
    #1 init_done = 1'b0;
    @(negedge clk);
  endtask

  // One transfer from an idle negedge: measures setup/pulse/wait phase lengths.
  task automatic do_xfer(input logic sel, input logic rs, input logic [7:0] data, input int exp_wait);
    int setup_n, pulse_n, wait_n, guard;
    logic held_ok;
    setup_n = 0; pulse_n = 0; wait_n = 0; guard = 0; held_ok = 1'b1;
    if (sel) begin req1_valid = 1'b1; req1_rs = rs; req1_data = data; end
    else     begin req0_valid = 1'b1; req0_rs = rs; req0_data = data; end
    #1;
    check("ready_onehot", {req1_ready, req0_ready}, sel ? 2 : 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = ~data; req1_data = ~data; req0_rs = ~rs; req1_rs = ~rs;
    @(negedge clk);
    while (busy && guard < 200) begin
      if (lcd_data !== data || lcd_rs !== rs || lcd_rw !== 1'b0 || req0_ready || req1_ready) held_ok = 1'b0;
      if (lcd_e) pulse_n++;
      else if (pulse_n == 0) setup_n++;
      else wait_n++;
      guard++;
      @(negedge clk);
    end
    check("xfer_done_in_time", busy, 0);
    check("setup_cycles", setup_n, SETUP);
    check("pulse_cycles", pulse_n, PULSE);
    check("wait_cycles", wait_n, exp_wait);
    check("byte_held", {held_ok, lcd_e, (lcd_data == data)}, 3'b101);
    $display("xfer sel=%0d rs=%0d data=%02h setup=%0d pulse=%0d wait=%0d", sel, rs, data, setup_n, pulse_n, wait_n);
  endtask

  initial begin
    int guard, prev_cyc;
    logic exp_sel;

    vecs[0] = '{sel: 1'b0, rs: 1'b1, data: 8'h41, exp_wait: CMDW};
    vecs[1] = '{sel: 1'b1, rs: 1'b0, data: 8'h01, exp_wait: CLRW};
    vecs[2] = '{sel: 1'b1, rs: 1'b1, data: 8'h01, exp_wait: CMDW};
    vecs[3] = '{sel: 1'b0, rs: 1'b0, data: 8'h02, exp_wait: CLRW};
    vecs[4] = '{sel: 1'b1, rs: 1'b0, data: 8'h38, exp_wait: CMDW};

    rst_n = 1'b0; init_done = 1'b0; init_rs = 1'b1; init_e = 1'b1; init_data = 8'hA5;
    req0_valid = 1'b1; req0_rs = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h00;

    // In reset: pass-through, no readies, busy
    #1;
    check("rst_pass_e", lcd_e, 1);
    check("rst_pass_data", lcd_data, 8'hA5);
    check("rst_readies", {req1_ready, req0_ready}, 0);
    check("rst_busy_rw", {busy, lcd_rw}, 2'b10);
    init_e = 1'b0;
    #1 check("rst_pass_e_low", lcd_e, 0);
    $display("reset pass-through sampled");

    // Out of reset, init_done low: still mirrors the init sequencer
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      init_e = i[0]; init_rs = ~i[0]; init_data = 8'h30 + 8'(i);
      #1;
      check("init_mirror", {lcd_e, lcd_rs, lcd_data}, {i[0], ~i[0], 8'h30 + 8'(i)});
      check("init_readies", {req1_ready, req0_ready, busy}, 3'b001);
      $display("init step %0d e=%0d data=%02h", i, lcd_e, lcd_data);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; init_e = 1'b0;
    init_done = 1'b1;
    @(posedge clk);
    #1 init_done = 1'b0;
    @(negedge clk);
    check("init_done_idle", busy, 0);
    init_e = 1'b1;
    #1 check("init_sticky_e", lcd_e, 0);
    init_e = 1'b0;
    check("idle_reset_byte", {lcd_rs, lcd_data}, 9'h000);
    $display("init handover done busy=%0d", busy);

    // Table-driven single transfers
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      do_xfer(vecs[v].sel, vecs[v].rs, vecs[v].data, vecs[v].exp_wait);
    end

    // Reset in the third pulse cycle drops lcd_e without a clock edge
    @(negedge clk);
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!lcd_e && guard < 20) begin guard++; @(negedge clk); end
    check("pulse_reached", lcd_e, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    init_e = 1'b0; init_data = 8'h00; init_rs = 1'b0;
    req0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midpulse_rst_e", lcd_e, 0);
    check("midpulse_rst_state", {busy, req0_ready, req1_ready}, 3'b100);
    $display("mid-pulse reset e=%0d busy=%0d", lcd_e, busy);
    req0_valid = 1'b0;
    bring_up();
    check("rst_recover_idle", {busy, lcd_rs, lcd_data}, 10'h000);

    // Both valid continuously: 0,1,0,1 with back-to-back spacing
    @(negedge clk);
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h30;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h31;
    exp_sel = 1'b0;
    prev_cyc = 0;
    #1;
    for (int t = 0; t < 4; t++) begin
      guard = 0;
      while (!(req0_ready || req1_ready) && guard < 60) begin guard++; @(negedge clk); end
      check("rr_grant", {req1_ready, req0_ready}, exp_sel ? 2 : 1);
      if (t > 0) check("rr_spacing", cyc - prev_cyc, 1 + SETUP + PULSE + CMDW);
      prev_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
      check("rr_one_cycle", {req1_ready, req0_ready, lcd_data}, {2'b00, exp_sel ? 8'h31 : 8'h30});
      $display("rr transfer %0d granted=%0d data=%02h", t, exp_sel, lcd_data);
      exp_sel = ~exp_sel;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    guard = 0;
    while (busy && guard < 60) begin guard++; @(negedge clk); end
    check("rr_drain", busy, 0);

    // Normal operation after all of the above
    @(negedge clk);
    do_xfer(1'b0, 1'b1, 8'h7E, CMDW);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_bus_scheduler.md
LCD_BUS_SCHEDULER -- requirements
Module: lcd_bus_scheduler

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, cycles lcd_data/lcd_rs are stable before lcd_e rises (minimum 1).
REQ-002 SHALL have parameter PULSE_CYC, default 50, cycles lcd_e is held high (minimum 1).
REQ-003 SHALL have parameter CMD_CYC, default 2000, post-pulse wait for ordinary writes (minimum 1).
REQ-004 SHALL have parameter CLEAR_CYC, default 90000, post-pulse wait for clear/home commands (minimum 1).
REQ-005 SHALL have ports: clk in 1, system clock; rst_n in 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports: init_data in 8, init_rs in 1, init_e in 1, init_done in 1, driven by the HD44780 init sequencer.
REQ-007 SHALL have ports: req0_valid in 1, req0_rs in 1, req0_data in 8, req0_ready out 1, for requester 0 (CPU port).
REQ-008 SHALL have ports: req1_valid in 1, req1_rs in 1, req1_data in 8, req1_ready out 1, for requester 1 (text refresh).
REQ-009 SHALL have ports: lcd_data out 8, lcd_rs out 1, lcd_rw out 1, lcd_e out 1, the physical LCD bus.
REQ-010 SHALL have port busy out 1, high in every state except S_IDLE.

Function
REQ-011 SHALL implement states S_INIT, S_IDLE, S_SETUP, S_PULSE, S_WAIT.
REQ-012 S_INIT: lcd_data/lcd_rs/lcd_e SHALL equal init_data/init_rs/init_e combinationally, and both readies SHALL be 0.
REQ-013 S_INIT -> S_IDLE SHALL occur on the first clk edge with init_done=1; init_done is ignored afterwards (sticky).
REQ-014 S_IDLE: lcd_e=0, lcd_data=last written byte, lcd_rs=last rs; both readies SHALL be 0 when no valid is asserted.
REQ-015 S_IDLE arbitration SHALL be round-robin: only one valid -> that requester is granted; both valid -> the requester not granted last.
REQ-016 reqN_ready SHALL be (state==S_IDLE) AND granted(N); it depends combinationally on the valids and at most one ready is high.
REQ-017 Transfer on valid&ready SHALL latch data/rs into internal registers, update the last-grant pointer and enter S_SETUP next cycle.
REQ-018 S_SETUP SHALL last exactly SETUP_CYC cycles with lcd_e=0 and the latched data/rs driven.
REQ-019 S_PULSE SHALL last exactly PULSE_CYC cycles with lcd_e=1 and the latched data/rs driven.
REQ-020 S_WAIT SHALL last exactly CLEAR_CYC cycles if rs=0 and data is 8'h01 or 8'h02, otherwise CMD_CYC cycles; then S_IDLE.
REQ-021 The delay counter SHALL be 32 bits, loaded with N-1 on state entry and decremented to 0, giving exactly N cycles.
REQ-022 lcd_rw SHALL be 0 in every state (write-only bus).
REQ-023 Request-to-request spacing for back-to-back grants SHALL be 1+SETUP_CYC+PULSE_CYC+wait cycles; no idle cycle beyond the single S_IDLE accept cycle.
REQ-024 Deassertion of valid outside S_IDLE SHALL NOT affect an operation in progress.
REQ-025 Request inputs changing after the accept cycle SHALL NOT alter the latched byte.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state S_INIT, counter 0, latched data 8'h00, latched rs 0, last-grant = requester 1 (so requester 0 wins the first tie).
REQ-027 During reset lcd_e SHALL follow init_e (pass-through), both readies SHALL be 0 and busy SHALL be 1.
REQ-028 Reset asserted mid-pulse SHALL drop a scheduler-driven lcd_e immediately, without waiting for a clock.

Structure
REQ-029 A shared package lcd_pkg SHALL hold the HD44780 command constants (clear 8'h01, home 8'h02, function set 8'h38, etc.), default timing values and the state encoding.
REQ-030 Round-robin grant logic SHALL be the sub-module lcd_rr_arb2 (inputs two valids and last-grant, output one-hot grant); all else stays in one module.

Verification (bench overrides SETUP_CYC=2, PULSE_CYC=4, CMD_CYC=10, CLEAR_CYC=40)
REQ-031 init_e toggled with init_done=0 -> lcd_e mirrors init_e same cycle, readies 0; init_done=1 one edge -> busy=0 next cycle.
REQ-032 req0 rs=1 data=8'h41 -> ready0 one cycle, lcd_e low 2 cycles, high 4 cycles, low 10 cycles, lcd_data=8'h41, rs=1, busy drops after 16 cycles.
REQ-033 req1 rs=0 data=8'h01 -> post-pulse wait exactly 40 cycles; same byte with rs=1 -> 10 cycles.
REQ-034 Both valids held continuously -> grants alternate 0,1,0,1 starting with 0; each ready high exactly one cycle per transfer.
REQ-035 rst_n pulled low in third S_PULSE cycle -> lcd_e=0 with no clock edge, state S_INIT; release and init_done=1 -> normal operation resumes.
REQ-036 req0_data changed the cycle after accept -> lcd_data keeps the accepted value until the next transfer.
